// File: rtl/mem_stage_hs.sv
// mem_stage_hs -- MEM pipeline stage between EXE and WB.
//
// Drives a request/grant/response data-memory port, builds byte strobes and
// lane-aligned store data, extracts and extends load data, flags misaligned
// or unsupported accesses, stalls upstream while an access is outstanding and
// registers the result into the MEM/WB pipeline register.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   ex_*                EXE/MEM register contents (valid, controls, data)
//   mem_stall           hold EXE/MEM and earlier stages (combinational)
//   fwd_rd_data         forwarding value: PC+4 or ALU result (combinational)
//   dm_req/we/addr/     data-memory request, driven only from state and the
//   dm_wstrb/wdata      captured request registers
//   dm_gnt              request accepted this cycle
//   dm_rvalid/rdata     read response (sampled only in WAIT)
//   wb_*                MEM/WB pipeline register outputs
module mem_stage_hs #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_mem_to_reg,
    input  logic                 ex_reg_write,
    input  logic                 ex_rd_src,
    input  logic [XLEN-1:0]      ex_alu_out,
    input  logic [XLEN-1:0]      ex_pc_to_reg,
    input  logic [XLEN-1:0]      ex_rs2_data,
    input  logic [4:0]           ex_rd_addr,
    input  logic [2:0]           ex_funct3,
    output logic                 mem_stall,
    output logic [XLEN-1:0]      fwd_rd_data,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [AW-1:0]        dm_addr,
    output logic [XLEN/8-1:0]    dm_wstrb,
    output logic [XLEN-1:0]      dm_wdata,
    input  logic                 dm_gnt,
    input  logic                 dm_rvalid,
    input  logic [XLEN-1:0]      dm_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic [4:0]           wb_rd_addr,
    output logic [XLEN-1:0]      wb_rd_data,
    output logic [XLEN-1:0]      wb_dout,
    output logic                 wb_fault
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    // Access size in bytes from funct3[1:0]: 1, 2, 4, 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // Mask covering the low sb bytes; a shift of XLEN bits yields all ones.
    function automatic logic [XLEN-1:0] byte_mask(input logic [3:0] sb);
        return ~({XLEN{1'b1}} << {sb, 3'b000});
    endfunction

    // ---------------- registers ----------------
    state_t             state_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [NB-1:0]      wstrb_q;
    logic [XLEN-1:0]    wdata_q;
    logic [2:0]         f3_q;
    logic [OW-1:0]      off_q;
    logic [4:0]         rd_addr_q;
    logic               reg_write_q;
    logic               mem_to_reg_q;
    logic [XLEN-1:0]    rd_data_q;

    logic               wb_valid_q;
    logic               wb_reg_write_q;
    logic               wb_mem_to_reg_q;
    logic [4:0]         wb_rd_addr_q;
    logic [XLEN-1:0]    wb_rd_data_q;
    logic [XLEN-1:0]    wb_dout_q;
    logic               wb_fault_q;

    // ---------------- EXE-side decode ----------------
    logic [OW-1:0]      ex_off;
    logic [3:0]         ex_sb;
    logic               is_mem;
    logic               code_ok;
    logic               misal;
    logic               fault;
    logic               start;
    logic [NB-1:0]      ex_strb;
    logic [XLEN-1:0]    ex_wdata;
    logic [AW-1:0]      ex_addr;

    assign fwd_rd_data = ex_rd_src ? ex_pc_to_reg : ex_alu_out;

    always_comb begin
        ex_off  = ex_alu_out[OW-1:0];
        ex_sb   = size_bytes(ex_funct3[1:0]);
        is_mem  = ex_mem_read | ex_mem_write;
        misal   = (4'(ex_off) & (ex_sb - 4'd1)) != 4'd0;
        code_ok = 1'b0;
        if (ex_mem_read) begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
                3'b011, 3'b110:                         code_ok = (XLEN == 64);
                default:                                code_ok = 1'b0;
            endcase
        end else begin
            // Stores care only about the size field.
            code_ok = (ex_funct3[1:0] != 2'b11) || (XLEN == 64);
        end
        fault    = ex_valid & is_mem & (~code_ok | misal);
        start    = ex_valid & is_mem & ~fault;
        ex_strb  = ex_mem_write ? ((~({NB{1'b1}} << ex_sb)) << ex_off) : '0;
        ex_wdata = (ex_rs2_data & byte_mask(ex_sb)) << {ex_off, 3'b000};
        ex_addr  = AW'(ex_alu_out);
        ex_addr[OW-1:0] = '0;
    end

    // ---------------- load extraction ----------------
    logic [XLEN-1:0] ld_sh, ld_mask, ld_top, ld_ext;
    logic            ld_neg;

    always_comb begin
        ld_sh   = dm_rdata >> {off_q, 3'b000};
        ld_mask = byte_mask(size_bytes(f3_q[1:0]));
        ld_top  = ld_mask & ~(ld_mask >> 1);        // sign-bit position
        ld_neg  = ~f3_q[2] & (|(ld_sh & ld_top));
        ld_ext  = (ld_sh & ld_mask) | (ld_neg ? ~ld_mask : '0);
    end

    // ---------------- stall ----------------
    always_comb begin
        case (state_q)
            S_IDLE:  mem_stall = start;
            S_REQ:   mem_stall = ~(dm_gnt & we_q);
            S_WAIT:  mem_stall = ~dm_rvalid;
            default: mem_stall = 1'b0;
        endcase
    end

    // ---------------- FSM + MEM/WB register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wstrb_q         <= '0;
            wdata_q         <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            rd_addr_q       <= '0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            rd_data_q       <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_addr_q    <= '0;
            wb_rd_data_q    <= '0;
            wb_dout_q       <= '0;
            wb_fault_q      <= 1'b0;
        end else begin
            // Bubble unless overridden by a pass-through or a completion.
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_addr_q    <= '0;
            wb_rd_data_q    <= '0;
            wb_dout_q       <= '0;
            wb_fault_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        we_q         <= ex_mem_write;
                        addr_q       <= ex_addr;
                        wstrb_q      <= ex_strb;
                        wdata_q      <= ex_wdata;
                        f3_q         <= ex_funct3;
                        off_q        <= ex_off;
                        rd_addr_q    <= ex_rd_addr;
                        reg_write_q  <= ex_reg_write;
                        mem_to_reg_q <= ex_mem_to_reg;
                        rd_data_q    <= fwd_rd_data;
                        state_q      <= S_REQ;
                    end else begin
                        wb_valid_q      <= ex_valid;
                        wb_reg_write_q  <= ex_valid & ex_reg_write & ~fault;
                        wb_mem_to_reg_q <= ex_mem_to_reg;
                        wb_rd_addr_q    <= ex_rd_addr;
                        wb_rd_data_q    <= fwd_rd_data;
                        wb_fault_q      <= fault;
                    end
                end
                S_REQ: begin
                    if (dm_gnt) begin
                        if (we_q) begin
                            wb_valid_q      <= 1'b1;
                            wb_reg_write_q  <= reg_write_q;
                            wb_mem_to_reg_q <= mem_to_reg_q;
                            wb_rd_addr_q    <= rd_addr_q;
                            wb_rd_data_q    <= rd_data_q;
                            state_q         <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dm_rvalid) begin
                        wb_valid_q      <= 1'b1;
                        wb_reg_write_q  <= reg_write_q;
                        wb_mem_to_reg_q <= mem_to_reg_q;
                        wb_rd_addr_q    <= rd_addr_q;
                        wb_rd_data_q    <= rd_data_q;
                        wb_dout_q       <= ld_ext;
                        state_q         <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dm_req   = (state_q == S_REQ);
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wstrb = wstrb_q;
    assign dm_wdata = wdata_q;

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_rd_data    = wb_rd_data_q;
    assign wb_dout       = wb_dout_q;
    assign wb_fault      = wb_fault_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: one XLEN=32 and one XLEN=64 instance.
// Expected MEM/WB results are queued when an instruction is presented and
// compared when the stage reports wb_valid.
module tb_mem_stage_hs;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- XLEN=32 instance ----------------
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd_src;
    logic [31:0] ex_alu_out, ex_pc_to_reg, ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        mem_stall, dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] fwd_rd_data, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_fault;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data, wb_dout;

    mem_stage_hs #(.XLEN(32), .AW(32)) dut32 (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd_src(ex_rd_src),
        .ex_alu_out(ex_alu_out), .ex_pc_to_reg(ex_pc_to_reg), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .fwd_rd_data(fwd_rd_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_dout(wb_dout), .wb_fault(wb_fault)
    );

    // ---------------- XLEN=64 instance ----------------
    logic        v6, rd6, wr6, m2r6, rw6, rs6;
    logic [63:0] alu6, pc6, rs2_6;
    logic [4:0]  ra6;
    logic [2:0]  f3_6;
    logic        stall6, req6, we6, gnt6, rvalid6;
    logic [63:0] fwd6, wdata6, rdata6;
    logic [31:0] addr6;
    logic [7:0]  wstrb6;
    logic        wbv6, wbrw6, wbm2r6, wbf6;
    logic [4:0]  wbra6;
    logic [63:0] wbrd6, wbdout6;

    mem_stage_hs #(.XLEN(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst),
        .ex_valid(v6), .ex_mem_read(rd6), .ex_mem_write(wr6),
        .ex_mem_to_reg(m2r6), .ex_reg_write(rw6), .ex_rd_src(rs6),
        .ex_alu_out(alu6), .ex_pc_to_reg(pc6), .ex_rs2_data(rs2_6),
        .ex_rd_addr(ra6), .ex_funct3(f3_6),
        .mem_stall(stall6), .fwd_rd_data(fwd6),
        .dm_req(req6), .dm_we(we6), .dm_addr(addr6), .dm_wstrb(wstrb6), .dm_wdata(wdata6),
        .dm_gnt(gnt6), .dm_rvalid(rvalid6), .dm_rdata(rdata6),
        .wb_valid(wbv6), .wb_reg_write(wbrw6), .wb_mem_to_reg(wbm2r6),
        .wb_rd_addr(wbra6), .wb_rd_data(wbrd6), .wb_dout(wbdout6), .wb_fault(wbf6)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_to_reg;
        logic        fault;
        logic [63:0] rd_data;
        logic [63:0] dout;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push32(input logic [4:0] ra, input logic rw, input logic m2r, input logic f,
                          input logic [63:0] rdd, input logic [63:0] dout);
        exp_t e;
        e.rd_addr = ra; e.reg_write = rw; e.mem_to_reg = m2r; e.fault = f;
        e.rd_data = rdd; e.dout = dout;
        q32.push_back(e);
    endtask

    task automatic push64(input logic [4:0] ra, input logic rw, input logic m2r, input logic f,
                          input logic [63:0] rdd, input logic [63:0] dout);
        exp_t e;
        e.rd_addr = ra; e.reg_write = rw; e.mem_to_reg = m2r; e.fault = f;
        e.rd_data = rdd; e.dout = dout;
        q64.push_back(e);
    endtask

    // Advance one edge, then score whatever the stages put into MEM/WB.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (wb_valid) begin
            if (q32.size() == 0) chk("wb32_unexpected", 64'(wb_valid), 64'd0);
            else begin
                e = q32.pop_front();
                chk("wb32_rd_addr",    64'(wb_rd_addr),    64'(e.rd_addr));
                chk("wb32_reg_write",  64'(wb_reg_write),  64'(e.reg_write));
                chk("wb32_mem_to_reg", 64'(wb_mem_to_reg), 64'(e.mem_to_reg));
                chk("wb32_fault",      64'(wb_fault),      64'(e.fault));
                chk("wb32_rd_data",    64'(wb_rd_data),    e.rd_data);
                chk("wb32_dout",       64'(wb_dout),       e.dout);
            end
        end
        if (wbv6) begin
            if (q64.size() == 0) chk("wb64_unexpected", 64'(wbv6), 64'd0);
            else begin
                e = q64.pop_front();
                chk("wb64_rd_addr",    64'(wbra6),  64'(e.rd_addr));
                chk("wb64_reg_write",  64'(wbrw6),  64'(e.reg_write));
                chk("wb64_mem_to_reg", 64'(wbm2r6), 64'(e.mem_to_reg));
                chk("wb64_fault",      64'(wbf6),   64'(e.fault));
                chk("wb64_rd_data",    wbrd6,       e.rd_data);
                chk("wb64_dout",       wbdout6,     e.dout);
            end
        end
    endtask

    task automatic drv32(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic rs, input logic [2:0] f3, input logic [4:0] ra,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rs2);
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
        ex_reg_write = rw; ex_rd_src = rs; ex_funct3 = f3; ex_rd_addr = ra;
        ex_alu_out = alu; ex_pc_to_reg = pc; ex_rs2_data = rs2;
    endtask

    task automatic drv64(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic rs, input logic [2:0] f3, input logic [4:0] ra,
                         input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] rs2);
        v6 = v; rd6 = rd; wr6 = wr; m2r6 = m2r; rw6 = rw; rs6 = rs; f3_6 = f3; ra6 = ra;
        alu6 = alu; pc6 = pc; rs2_6 = rs2;
    endtask

    task automatic idle32();
        drv32(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic idle64();
        drv64(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        idle32(); idle64();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        gnt6 = 1'b0; rvalid6 = 1'b0; rdata6 = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_wb_valid", 64'(wb_valid),  64'd0);
        chk("rst_dm_req",   64'(dm_req),    64'd0);
        chk("rst_stall",    64'(mem_stall), 64'd0);
        chk("rst_wb_fault", 64'(wb_fault),  64'd0);
        chk("rst_req64",    64'(req6),      64'd0);
        rst = 1'b1;
        tick();

        // Non-memory op: forwarded PC+4, one cycle, no stall
        drv32(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 5'd3, 32'h0000DEAD, 32'h00000104, 32'd0);
        #1;
        chk("alu_fwd",   64'(fwd_rd_data), 64'h104);
        chk("alu_stall", 64'(mem_stall),   64'd0);
        push32(5'd3, 1'b1, 1'b0, 1'b0, 64'h104, 64'd0);
        tick();
        chk("alu_wbv", 64'(wb_valid), 64'd1);
        idle32();

        // Store byte at 0x1003, gnt immediately
        drv32(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h00001003, 32'd0, 32'h12345678);
        dm_gnt = 1'b1;
        #1;
        chk("sb_stall0", 64'(mem_stall), 64'd1);
        chk("sb_noreq0", 64'(dm_req),    64'd0);
        push32(5'd0, 1'b0, 1'b0, 1'b0, 64'h1003, 64'd0);
        tick();
        chk("sb_bubble", 64'(wb_valid),  64'd0);
        chk("sb_req",    64'(dm_req),    64'd1);
        chk("sb_we",     64'(dm_we),     64'd1);
        chk("sb_addr",   64'(dm_addr),   64'h1000);
        chk("sb_wstrb",  64'(dm_wstrb),  64'b1000);
        chk("sb_wdata",  64'(dm_wdata),  64'h78000000);
        chk("sb_stall1", 64'(mem_stall), 64'd0);
        tick();
        chk("sb_wbv", 64'(wb_valid), 64'd1);
        idle32(); dm_gnt = 1'b0;

        // Signed half load at 0x2002, gnt cycle 1, rvalid cycle 4
        drv32(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 5'd5, 32'h00002002, 32'd0, 32'd0);
        push32(5'd5, 1'b1, 1'b1, 1'b0, 64'h2002, 64'hFFFF8001);
        #1;
        chk("lh_stall_c0", 64'(mem_stall), 64'd1);
        tick();
        dm_gnt = 1'b1;
        #1;
        chk("lh_stall_c1", 64'(mem_stall), 64'd1);
        chk("lh_req",      64'(dm_req),    64'd1);
        chk("lh_we",       64'(dm_we),     64'd0);
        chk("lh_addr",     64'(dm_addr),   64'h2000);
        chk("lh_wstrb",    64'(dm_wstrb),  64'd0);
        tick();
        dm_gnt = 1'b0;
        #1;
        chk("lh_stall_c2", 64'(mem_stall), 64'd1);
        chk("lh_wait_req", 64'(dm_req),    64'd0);
        tick();
        chk("lh_stall_c3", 64'(mem_stall), 64'd1);
        tick();
        dm_rvalid = 1'b1; dm_rdata = 32'h8001ABCD;
        #1;
        chk("lh_stall_c4", 64'(mem_stall), 64'd0);
        tick();
        chk("lh_wbv", 64'(wb_valid), 64'd1);
        dm_rvalid = 1'b0; idle32();

        // Unsigned byte load at offset 1
        drv32(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 5'd6, 32'h00004001, 32'd0, 32'd0);
        push32(5'd6, 1'b1, 1'b1, 1'b0, 64'h4001, 64'h000000F2);
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h0000F200;
        tick();
        chk("lbu_wbv", 64'(wb_valid), 64'd1);
        dm_rvalid = 1'b0; idle32();

        // Misaligned word load: fault, no request, no stall
        drv32(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd7, 32'h00003002, 32'd0, 32'd0);
        #1;
        chk("mis_stall", 64'(mem_stall), 64'd0);
        push32(5'd7, 1'b0, 1'b1, 1'b1, 64'h3002, 64'd0);
        tick();
        chk("mis_fault", 64'(wb_fault), 64'd1);
        chk("mis_noreq", 64'(dm_req),   64'd0);

        // funct3=011 on XLEN=32 is unsupported
        drv32(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 5'd8, 32'h00003008, 32'd0, 32'd0);
        #1;
        chk("ld011_stall", 64'(mem_stall), 64'd0);
        push32(5'd8, 1'b0, 1'b1, 1'b1, 64'h3008, 64'd0);
        tick();
        chk("ld011_fault", 64'(wb_fault), 64'd1);
        chk("ld011_noreq", 64'(dm_req),   64'd0);
        idle32();

        // Store half at offset 2, gnt delayed; request must ignore ex_* changes
        drv32(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 5'd0, 32'h00000012, 32'd0, 32'hAABBCCDD);
        push32(5'd0, 1'b0, 1'b0, 1'b0, 64'h12, 64'd0);
        tick();
        drv32(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0000FFFF, 32'd0, 32'd0);
        #1;
        chk("sh_stall_nognt", 64'(mem_stall), 64'd1);
        chk("sh_wstrb_hold",  64'(dm_wstrb),  64'b1100);
        tick();
        dm_gnt = 1'b1;
        #1;
        chk("sh_addr",  64'(dm_addr),   64'h10);
        chk("sh_wdata", 64'(dm_wdata),  64'hCCDD0000);
        chk("sh_stall", 64'(mem_stall), 64'd0);
        tick();
        chk("sh_wbv", 64'(wb_valid), 64'd1);
        idle32(); dm_gnt = 1'b0;

        // XLEN=64 dword store at 0x08
        drv64(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 5'd0, 64'h8, 64'd0, 64'h1122334455667788);
        gnt6 = 1'b1;
        push64(5'd0, 1'b0, 1'b0, 1'b0, 64'h8, 64'd0);
        #1;
        chk("sd_stall", 64'(stall6), 64'd1);
        tick();
        chk("sd_req",   64'(req6),   64'd1);
        chk("sd_addr",  64'(addr6),  64'h8);
        chk("sd_wstrb", 64'(wstrb6), 64'hFF);
        chk("sd_wdata", wdata6,      64'h1122334455667788);
        tick();
        chk("sd_wbv", 64'(wbv6), 64'd1);
        idle64();

        // XLEN=64 signed word load from upper lane
        drv64(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 64'h4, 64'd0, 64'd0);
        push64(5'd9, 1'b1, 1'b1, 1'b0, 64'h4, 64'hFFFFFFFF80000000);
        tick();
        chk("lw64_addr",  64'(addr6),  64'h0);
        chk("lw64_wstrb", 64'(wstrb6), 64'h0);
        tick();
        gnt6 = 1'b0; rvalid6 = 1'b1; rdata6 = 64'h80000000_00000000;
        tick();
        chk("lw64_wbv", 64'(wbv6), 64'd1);
        rvalid6 = 1'b0; idle64();

        // Reset while waiting for read data; late rvalid must be ignored
        drv32(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h00005000, 32'd0, 32'd0);
        dm_gnt = 1'b1;
        tick();
        tick();
        idle32(); dm_gnt = 1'b0;
        #1;
        chk("rw_wait_stall", 64'(mem_stall), 64'd1);
        rst = 1'b0;
        tick();
        chk("rw_wbv",      64'(wb_valid),      64'd0);
        chk("rw_wbrw",     64'(wb_reg_write),  64'd0);
        chk("rw_wbm2r",    64'(wb_mem_to_reg), 64'd0);
        chk("rw_wbra",     64'(wb_rd_addr),    64'd0);
        chk("rw_wbrd",     64'(wb_rd_data),    64'd0);
        chk("rw_wbdout",   64'(wb_dout),       64'd0);
        chk("rw_wbfault",  64'(wb_fault),      64'd0);
        chk("rw_stall",    64'(mem_stall),     64'd0);
        chk("rw_req",      64'(dm_req),        64'd0);
        chk("rw_addr",     64'(dm_addr),       64'd0);
        rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hFFFFFFFF;
        #1;
        chk("rw_post_stall", 64'(mem_stall), 64'd0);
        tick();
        chk("rw_post_wbv",   64'(wb_valid), 64'd0);
        chk("rw_post_dout",  64'(wb_dout),  64'd0);
        chk("rw_post_req",   64'(dm_req),   64'd0);
        dm_rvalid = 1'b0;
        tick();

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory pipeline stage that sits between EXE and WB in the RISC-V core. It drives a request/grant/response data-memory port with multi-cycle latency support. It generates active-high byte strobes and lane-aligned store data for any XLEN, and extracts plus sign- or zero-extends load data from the correct lane. It also detects misaligned or unsupported accesses, stalls upstream while a memory access is outstanding, and registers results into the MEM/WB pipeline register.

## Interface
- XLEN, 32, data width; 32 or 64. NB = XLEN/8 byte lanes; OW = log2(NB) offset bits.
- AW, 32, data-memory address width.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- ex_valid  input  1  EXE/MEM register holds a valid instruction.
- ex_mem_read, ex_mem_write  input  1 each  load / store.
- ex_mem_to_reg, ex_reg_write, ex_rd_src  input  1 each  WB mux select, register write enable, and select of PC+4 over ALU result.
- ex_alu_out  input  XLEN  effective address or ALU result.
- ex_pc_to_reg  input  XLEN  PC+4 value.
- ex_rs2_data  input  XLEN  store source.
- ex_rd_addr  input  5  destination register.
- ex_funct3  input  3  access size and sign.
- mem_stall  output  1  EXE/MEM and all earlier stages must hold.
- fwd_rd_data  output  XLEN  combinational: ex_rd_src ? ex_pc_to_reg : ex_alu_out.
- dm_req  output  1  request valid.
- dm_we  output  1  1 = write.
- dm_addr  output  AW  address, with the low OW bits cleared.
- dm_wstrb  output  NB  active-high byte write strobes.
- dm_wdata  output  XLEN  lane-aligned store data.
- dm_gnt  input  1  request accepted this cycle.
- dm_rvalid  input  1  read data valid.
- dm_rdata  input  XLEN  read data.
- wb_valid, wb_reg_write, wb_mem_to_reg  output  1 each  MEM/WB control.
- wb_rd_addr  output  5  MEM/WB destination register.
- wb_rd_data  output  XLEN  registered non-memory result.
- wb_dout  output  XLEN  registered, extended load data.
- wb_fault  output  1  registered; instruction was misaligned or had an unsupported funct3.

## Operation
- **Access sizes** (funct3):
  - 000 byte, signed; 100 byte, unsigned.
  - 001 half, signed; 101 half, unsigned.
  - 010 word, signed. 110 word, unsigned, legal only when XLEN=64.
  - 011 dword, legal only when XLEN=64.
  - Any other code, or an XLEN-gated code when XLEN=32, is unsupported. Stores use size only.
- **Misalignment:** an access is misaligned when addr mod size ≠ 0, where off = addr[OW-1:0].
- **Strobes and store data:**
  - dm_wstrb = ((1<<size)-1) << off when writing; all zeros for reads.
  - dm_wdata = rs2 low size bytes shifted left by off*8; the other lanes are 0.
- **Load data:** dm_rdata is shifted right by off*8, truncated to size, then sign-extended from bit size*8-1 (signed codes) or zero-extended.
- **State machine:** states IDLE, REQ, WAIT.
  - IDLE, with ex_valid and (read|write) and the access legal:
    - capture we, addr, strobes, wdata, funct3, off, rd_addr and the control bits into internal registers;
    - go to REQ;
    - load a bubble into MEM/WB.
  - IDLE, any other case (non-memory instruction, faulting access, or !ex_valid):
    - load MEM/WB directly: wb_valid=ex_valid, wb_rd_data=fwd_rd_data, wb_dout=0;
    - for a faulting access, wb_fault=1 and wb_reg_write=0.
  - REQ:
    - dm_req=1, with all dm_* outputs driven from the captured registers and held stable until dm_gnt.
    - On gnt for a write: complete (MEM/WB gets wb_valid=1, reg_write as captured), go to IDLE.
    - On gnt for a read: go to WAIT.
  - WAIT:
    - dm_req=0; dm_rvalid is sampled only in this state.
    - On rvalid: wb_dout = extended data, wb_valid=1, go to IDLE.
- **Stall and bubbles:**
  - mem_stall = (IDLE and a legal memory op is presented) or (REQ and not (gnt and write)) or (WAIT and !rvalid).
  - MEM/WB receives a bubble (wb_valid=0, wb_reg_write=0, wb_fault=0) on every edge except a pass-through or a completion.
- **Reset:** rst=0 at any edge forces IDLE, dm_req=0, and clears every wb_* output and captured register to 0. A dm_rvalid arriving after reset is ignored.

## Timing
- Non-memory or faulting instruction: 1 cycle to MEM/WB, no stall.
- Store, with gnt in the first REQ cycle: accepted at edge 0, completes at edge 1; mem_stall is high for 1 cycle.
- Load, with gnt in cycle 1 and rvalid in cycle 2: completes at edge 2; mem_stall is high for 2 cycles.
- Each extra cycle without gnt or rvalid adds one stall cycle.
- mem_stall is low in the completion cycle, so EXE advances on the same edge that MEM/WB loads the result.
- fwd_rd_data and mem_stall are combinational. dm_* outputs are combinational from state and captured registers only, never from ex_* inputs.

## Test plan
- **Store byte, XLEN=32:** funct3=000, addr=0x1003, rs2=0x12345678, gnt immediate.
  - dm_wstrb=1000, dm_wdata=0x78000000, dm_addr=0x1000.
  - mem_stall high 1 cycle; wb_valid at edge 1.
- **Signed half load, XLEN=32:** funct3=001, addr=0x2002, rdata=0x8001ABCD, gnt cycle 1, rvalid cycle 4.
  - wb_dout=0xFFFF8001; mem_stall high cycles 0–3.
- **Unsigned byte load:** funct3=100, addr offset 1, rdata=0x0000F200 → wb_dout=0x000000F2.
- **Misaligned word load:** addr=0x3002.
  - No dm_req; wb_fault=1, wb_reg_write=0, mem_stall=0.
- **XLEN=64 dword store:** addr=0x08, rs2=0x1122334455667788 → wstrb=0xFF, wdata equal to rs2.
- **XLEN=32 funct3=011, then reset:** funct3=011 → wb_fault=1. Then reset while in WAIT, with rvalid pulsed the next cycle:
  - state returns to IDLE;
  - all wb_* outputs stay 0;
  - mem_stall=0.
